mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the processor's data-memory bus. It answers the same Address/WriteData/MemRead/MemWrite requests the core issues in its MEM stage.
- Provides a PortOut register, a synchronized PortIn with edge capture, and a down-counting timer with an interrupt output.
- Sits beside the data memory. The top level muxes ReadData into the MEM/WB path when Hit=1.

---
 rtl/mmio_pkg.sv | 39 +++
 rtl/mmio_timer.sv | 55 +++++
 rtl/mmio_port_responder.sv | 137 +++++++++++++
 tb/tb_mmio_port_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO port responder: register offsets
// (word index inside the 32-byte window), timer control/status bit
// positions, the write-strobe bundle and the window-decode helper.
package mmio_pkg;

   // Word offsets, i.e. Address[4:2]
   localparam logic [2:0] OFF_PORT_OUT    = 3'd0;
   localparam logic [2:0] OFF_PORT_IN     = 3'd1;
   localparam logic [2:0] OFF_IN_EDGE     = 3'd2;
   localparam logic [2:0] OFF_TIMER_CTRL  = 3'd3;
   localparam logic [2:0] OFF_TIMER_LOAD  = 3'd4;
   localparam logic [2:0] OFF_TIMER_COUNT = 3'd5;
   localparam logic [2:0] OFF_TIMER_STAT  = 3'd6;
   localparam logic [2:0] OFF_EDGE_MASK   = 3'd7;

   // TIMER_CTRL / TIMER_STAT bit indices
   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_TIE  = 2;
   localparam int CTRL_W    = 3;
   localparam int STAT_EXP  = 0;

   // One-hot write strobes, already qualified by Hit & MemWrite
   typedef struct packed {
      logic port_out;
      logic in_edge;
      logic ctrl;
      logic load;
      logic stat;
      logic mask;
   } wr_strobe_t;

   // Window is 32 bytes, so only bits [31:5] take part in the match
   function automatic logic in_window(input logic [31:0] addr,
                                      input logic [31:0] base);
      return addr[31:5] == base[31:5];
   endfunction

endpackage

// File: rtl/mmio_timer.sv
// Down-counting timer: LOAD/COUNT/CTRL/EXP state with one-shot and
// auto-reload expiry. Inputs are pre-decoded write strobes.
module mmio_timer
   import mmio_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              ctrl_we,
   input  logic              load_we,
   input  logic              stat_we,
   input  logic [31:0]       wdata,
   output logic [CTRL_W-1:0] ctrl,
   output logic [31:0]       load,
   output logic [31:0]       count,
   output logic              exp
);

   logic en, auto_rl, fire;

   assign en      = ctrl[CTRL_EN];
   assign auto_rl = ctrl[CTRL_AUTO];
   // Expiry happens on the cycle the running counter sits at zero
   assign fire    = en && (count == 32'd0);

   // Reload value: software-only
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        load <= '0;
      else if (load_we) load <= wdata;
   end

   // Counter: a LOAD write beats both decrement and auto-reload
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          count <= '0;
      else if (load_we)   count <= wdata;
      else if (en) begin
         if (count != 32'd0) count <= count - 32'd1;
         else if (auto_rl)   count <= load;
      end
   end

   // Control: a software write beats the one-shot EN clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                ctrl <= '0;
      else if (ctrl_we)         ctrl <= wdata[CTRL_W-1:0];
      else if (fire && !auto_rl) ctrl[CTRL_EN] <= 1'b0;
   end

   // Expired flag: hardware set beats a same-cycle W1C
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                          exp <= 1'b0;
      else if (fire)                      exp <= 1'b1;
      else if (stat_we && wdata[STAT_EXP]) exp <= 1'b0;
   end

endmodule

// File: rtl/mmio_port_responder.sv
// MMIO responder on the data-memory bus: PORT_OUT register, synchronized
// PORT_IN with rising-edge capture, and a timer with interrupt output.
// Reads are combinational; writes commit on the rising clk edge.
// Optional macro MMIO_EDGE_IRQ_EN adds the RW EDGE_MASK register at 0x1C
// and lets masked input edges raise IRQ.
module mmio_port_responder
   import mmio_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
   parameter int          IN_WIDTH    = 8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         Address,
   input  logic [31:0]         WriteData,
   input  logic                MemWrite,
   input  logic                MemRead,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         ReadData,
   output logic                Hit,
   output logic [31:0]         PortOut,
   output logic                IRQ
);

   logic [2:0]                              offset;
   wr_strobe_t                              wr;
   logic [SYNC_STAGES-1:0][IN_WIDTH-1:0]    sync_ff;
   logic [IN_WIDTH-1:0]                     in_sync, in_prev, in_rise, in_edge;
   logic [CTRL_W-1:0]                       t_ctrl;
   logic [31:0]                             t_load, t_count;
   logic                                    t_exp, edge_irq;
   logic [31:0]                             mask_rd, rd_val;
   logic                                    unused;

   assign Hit    = in_window(Address, BASE_ADDR);
   assign offset = Address[4:2];

   // Decode one write strobe per register; nothing fires outside the window
   always_comb begin
      wr = '0;
      if (Hit && MemWrite) begin
         case (offset)
            OFF_PORT_OUT:   wr.port_out = 1'b1;
            OFF_IN_EDGE:    wr.in_edge  = 1'b1;
            OFF_TIMER_CTRL: wr.ctrl     = 1'b1;
            OFF_TIMER_LOAD: wr.load     = 1'b1;
            OFF_TIMER_STAT: wr.stat     = 1'b1;
            OFF_EDGE_MASK:  wr.mask     = 1'b1;
            default: ;
         endcase
      end
   end

   // Output port register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            PortOut <= '0;
      else if (wr.port_out) PortOut <= WriteData;
   end

   // Input synchronizer chain; stage SYNC_STAGES-1 is the usable value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) sync_ff <= '0;
      else       sync_ff <= {sync_ff[SYNC_STAGES-2:0], PortIn};
   end

   assign in_sync = sync_ff[SYNC_STAGES-1];
   assign in_rise = in_sync & ~in_prev;

   // One-cycle delayed copy used for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_prev <= '0;
      else       in_prev <= in_sync;
   end

   // Sticky edge capture, W1C; a new rise on the same bit wins over the clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) in_edge <= '0;
      else       in_edge <= in_rise |
                            (in_edge & ~(wr.in_edge ? WriteData[IN_WIDTH-1:0] : '0));
   end

`ifdef MMIO_EDGE_IRQ_EN
   logic [IN_WIDTH-1:0] edge_mask;

   // Per-bit enable of input edges onto IRQ
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        edge_mask <= '0;
      else if (wr.mask) edge_mask <= WriteData[IN_WIDTH-1:0];
   end

   assign edge_irq = |(in_edge & edge_mask);
   assign mask_rd  = 32'(edge_mask);
   assign unused   = ^Address[1:0];
`else
   assign edge_irq = 1'b0;
   assign mask_rd  = '0;
   assign unused   = ^{Address[1:0], wr.mask};
`endif

   mmio_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .ctrl_we (wr.ctrl),
      .load_we (wr.load),
      .stat_we (wr.stat),
      .wdata   (WriteData),
      .ctrl    (t_ctrl),
      .load    (t_load),
      .count   (t_count),
      .exp     (t_exp)
   );

   // Interrupt is registered from the current flag state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) IRQ <= 1'b0;
      else       IRQ <= (t_exp & t_ctrl[CTRL_TIE]) | edge_irq;
   end

   // Combinational read mux; gated to zero unless a mapped read is active
   always_comb begin
      rd_val = '0;
      case (offset)
         OFF_PORT_OUT:    rd_val = PortOut;
         OFF_PORT_IN:     rd_val = 32'(in_sync);
         OFF_IN_EDGE:     rd_val = 32'(in_edge);
         OFF_TIMER_CTRL:  rd_val = 32'(t_ctrl);
         OFF_TIMER_LOAD:  rd_val = t_load;
         OFF_TIMER_COUNT: rd_val = t_count;
         OFF_TIMER_STAT:  rd_val = 32'(t_exp);
         OFF_EDGE_MASK:   rd_val = mask_rd;
         default:         rd_val = '0;
      endcase
      ReadData = (Hit && MemRead) ? rd_val : 32'd0;
   end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Randomized + directed bench for mmio_port_responder against a
// cycle-level behavioural model of the register map.
module tb_mmio_port_responder;

   localparam logic [31:0] BASE = 32'hFFFF0000;
   localparam int          IW   = 8;
   localparam int          SS   = 2;
`ifdef MMIO_EDGE_IRQ_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   Address, WriteData, ReadData, PortOut;
   logic          MemWrite, MemRead, Hit, IRQ;
   logic [IW-1:0] PortIn, pin;

   always #5 clk = ~clk;

   mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(IW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
      .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
      .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .IRQ(IRQ)
   );

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0]   m_out, m_load, m_count;
   bit            m_en, m_auto, m_tie, m_exp, m_irq;
   logic [IW-1:0] m_edge, m_mask;
   logic [IW-1:0] pin_q[$];   // pin_q[k] = PortIn sampled k+1 edges ago

   function automatic void m_reset();
      m_out = 0; m_load = 0; m_count = 0;
      m_en = 0; m_auto = 0; m_tie = 0; m_exp = 0; m_irq = 0;
      m_edge = 0; m_mask = 0;
      pin_q.delete();
      for (int i = 0; i <= SS; i++) pin_q.push_back('0);
   endfunction

   function automatic logic [31:0] m_read(input logic [2:0] off);
      case (off)
         3'd0: return m_out;
         3'd1: return 32'(pin_q[SS-1]);
         3'd2: return 32'(m_edge);
         3'd3: return {29'd0, m_tie, m_auto, m_en};
         3'd4: return m_load;
         3'd5: return m_count;
         3'd6: return {31'd0, m_exp};
         default: return EDGE_EN ? 32'(m_mask) : 32'd0;
      endcase
   endfunction

   // Advance model one clock edge using the inputs currently on the bus
   function automatic void m_clock();
      bit            hit, we, fire, nirq;
      logic [2:0]    off;
      logic [IW-1:0] rise;
      if (reset) begin m_reset(); return; end
      hit  = Address[31:5] == BASE[31:5];
      we   = hit && MemWrite;
      off  = Address[4:2];
      fire = m_en && (m_count == 0);
      rise = pin_q[SS-1] & ~pin_q[SS];
      nirq = (m_exp && m_tie) || (EDGE_EN && ((m_edge & m_mask) != 0));
      if (fire) m_exp = 1;
      else if (we && off == 6 && WriteData[0]) m_exp = 0;
      if (we && off == 4) m_count = WriteData;
      else if (m_en) begin
         if (m_count != 0) m_count = m_count - 1;
         else if (m_auto)  m_count = m_load;
      end
      if (we && off == 4) m_load = WriteData;
      if (we && off == 3) {m_tie, m_auto, m_en} = WriteData[2:0];
      else if (fire && !m_auto) m_en = 0;
      if (we && off == 2) m_edge = m_edge & ~WriteData[IW-1:0];
      m_edge = m_edge | rise;
      if (we && off == 7 && EDGE_EN) m_mask = WriteData[IW-1:0];
      if (we && off == 0) m_out = WriteData;
      pin_q.push_front(PortIn);
      void'(pin_q.pop_back());
      m_irq = nirq;
   endfunction

   // ---------------- bus tasks ----------------
   // Called at a negedge: drive, check combinational + registered outputs,
   // take one rising edge, update model, return at next negedge.
   task automatic step(input logic [31:0] a, input logic [31:0] d,
                       input bit rd, input bit wr, output logic [31:0] rdv);
      bit exp_hit;
      Address = a; WriteData = d; MemRead = rd; MemWrite = wr; PortIn = pin;
      #2;
      exp_hit = a[31:5] == BASE[31:5];
      rdv = ReadData;
      chk("hit", {31'd0, Hit}, {31'd0, exp_hit});
      chk("rdata", ReadData, (exp_hit && rd) ? m_read(a[4:2]) : 32'd0);
      chk("portout", PortOut, m_out);
      chk("irq", {31'd0, IRQ}, {31'd0, m_irq});
      @(posedge clk);
      m_clock();
      @(negedge clk);
   endtask

   task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] r;
      step(a, d, 1'b0, 1'b1, r);
   endtask

   task automatic idle(input int n);
      logic [31:0] r;
      for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0, r);
   endtask

   task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] want);
      logic [31:0] r;
      step(a, 32'h0, 1'b1, 1'b0, r);
      chk(tag, r, want);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] a, d, r;
      reset = 1'b1; Address = 0; WriteData = 0; MemRead = 0; MemWrite = 0;
      pin = 0; PortIn = 0;
      m_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // reset state
      for (int i = 0; i < 8; i++) rd_chk("reset_rd", BASE + 32'(i * 4), 32'd0);
      chk("reset_irq", {31'd0, IRQ}, 32'd0);

      // PORT_OUT write/readback
      wr_reg(BASE, 32'hDEADBEEF);
      chk("portout_wr", PortOut, 32'hDEADBEEF);
      rd_chk("portout_rd", BASE, 32'hDEADBEEF);

      // window boundaries
      wr_reg(32'hFFFF0020, 32'h1);
      wr_reg(32'h10010000, 32'h2);
      chk("window_wr", PortOut, 32'hDEADBEEF);
      rd_chk("byte_lane", 32'hFFFF0003, 32'hDEADBEEF);
      rd_chk("outside_rd", 32'hFFFF0020, 32'h0);

      // input sync + edge capture
      pin = 8'h05;
      idle(1);
      rd_chk("port_in_1", BASE + 4, 32'h00);
      rd_chk("port_in_2", BASE + 4, 32'h05);
      rd_chk("in_edge", BASE + 8, 32'h05);
      wr_reg(BASE + 8, 32'h01);
      rd_chk("in_edge_w1c", BASE + 8, 32'h04);
      pin = 8'h01;
      idle(3);
      wr_reg(BASE + 8, 32'h04);
      rd_chk("in_edge_clr", BASE + 8, 32'h00);
      pin = 8'h05;
      idle(2);
      wr_reg(BASE + 8, 32'h04);               // rise lands on this edge
      rd_chk("edge_set_wins", BASE + 8, 32'h04);
      wr_reg(BASE + 8, 32'hFF);

      // edge interrupt (mask bit 1 only)
      wr_reg(BASE + 32'h1C, 32'h02);
      rd_chk("edge_mask_rd", BASE + 32'h1C, EDGE_EN ? 32'h02 : 32'h0);
      pin = 8'h07;
      idle(4);
      chk("edge_irq_b1", {31'd0, IRQ}, {31'd0, EDGE_EN});
      wr_reg(BASE + 8, 32'hFF);
      idle(1);
      chk("edge_irq_clr", {31'd0, IRQ}, 32'd0);
      pin = 8'h06;
      idle(3);
      pin = 8'h07;
      idle(4);
      chk("edge_irq_b0", {31'd0, IRQ}, 32'd0);
      wr_reg(BASE + 8, 32'hFF);
      idle(1);

      // one-shot timer
      wr_reg(BASE + 32'h10, 32'd3);
      wr_reg(BASE + 32'h0C, 32'h5);
      rd_chk("os_cnt3", BASE + 32'h14, 32'd3);
      rd_chk("os_cnt2", BASE + 32'h14, 32'd2);
      rd_chk("os_cnt1", BASE + 32'h14, 32'd1);
      rd_chk("os_cnt0", BASE + 32'h14, 32'd0);
      chk("os_irq_pre", {31'd0, IRQ}, 32'd0);
      rd_chk("os_exp", BASE + 32'h18, 32'd1);
      chk("os_irq", {31'd0, IRQ}, 32'd1);
      rd_chk("os_en_clr", BASE + 32'h0C, 32'h4);
      rd_chk("os_hold", BASE + 32'h14, 32'd0);
      wr_reg(BASE + 32'h18, 32'h1);
      idle(1);
      chk("os_irq_clr", {31'd0, IRQ}, 32'd0);

      // auto-reload
      wr_reg(BASE + 32'h10, 32'd1);
      wr_reg(BASE + 32'h0C, 32'h3);
      rd_chk("ar_cnt1", BASE + 32'h14, 32'd1);
      rd_chk("ar_cnt0", BASE + 32'h14, 32'd0);
      rd_chk("ar_cnt1b", BASE + 32'h14, 32'd1);
      rd_chk("ar_exp", BASE + 32'h18, 32'd1);
      wr_reg(BASE + 32'h18, 32'h1);
      rd_chk("ar_exp_clr", BASE + 32'h18, 32'd0);
      idle(1);
      wr_reg(BASE + 32'h18, 32'h1);           // expiry lands on this edge
      rd_chk("ar_set_wins", BASE + 32'h18, 32'd1);

      // reset mid-count
      wr_reg(BASE + 32'h10, 32'd100);
      idle(3);
      reset = 1'b1;
      #1;
      m_reset();
      rd_chk("rst_cnt", BASE + 32'h14, 32'd0);
      rd_chk("rst_exp", BASE + 32'h18, 32'd0);
      reset = 1'b0;
      idle(1);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         a = ($urandom_range(3) != 0) ? (BASE | ($urandom & 32'h1F)) : $urandom;
         d = (a[4:2] == 3'd4) ? $urandom_range(6) : $urandom;
         if ($urandom_range(3) == 0) pin = IW'($urandom);
         if ($urandom_range(150) == 0) begin
            reset = 1'b1;
            #1;
            m_reset();
            idle(1);
            reset = 1'b0;
         end
         step(a, d, 1'($urandom), $urandom_range(2) == 0, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
